// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, command struct and the combinational evaluator.
package alu_pkg;

  localparam int unsigned RES_W  = 8;
  localparam int unsigned OPND_W = 4;

  localparam logic [OPND_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OPND_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OPND_W-1:0] OP_MUL  = 4'd2;
  localparam logic [OPND_W-1:0] OP_DIV  = 4'd3;
  localparam logic [OPND_W-1:0] OP_AND  = 4'd4;
  localparam logic [OPND_W-1:0] OP_OR   = 4'd5;
  localparam logic [OPND_W-1:0] OP_XOR  = 4'd6;
  localparam logic [OPND_W-1:0] OP_NAND = 4'd7;
  localparam logic [OPND_W-1:0] OP_NOR  = 4'd8;
  localparam logic [OPND_W-1:0] OP_NOT  = 4'd9;
  localparam logic [OPND_W-1:0] OP_MOD  = 4'd10;
  localparam logic [OPND_W-1:0] OP_SHL  = 4'd11;
  localparam logic [OPND_W-1:0] OP_SHR  = 4'd12;
  localparam logic [OPND_W-1:0] OP_LAST = 4'd12;

  typedef struct packed {
    logic [OPND_W-1:0] op;
    logic [OPND_W-1:0] x;
    logic [OPND_W-1:0] y;
  } alu_cmd_t;

  // Operands are zero-extended first so arithmetic wraps modulo 2^RES_W.
  function automatic logic [RES_W-1:0] alu_eval(input logic [OPND_W-1:0] op,
                                                input logic [OPND_W-1:0] x,
                                                input logic [OPND_W-1:0] y);
    logic [RES_W-1:0] xe;
    logic [RES_W-1:0] ye;
    logic [RES_W-1:0] r;
    xe = {4'b0000, x};
    ye = {4'b0000, y};
    r  = '0;
    case (op)
      OP_ADD:  r = xe + ye;
      OP_SUB:  r = xe - ye;
      OP_MUL:  r = xe * ye;
      OP_DIV:  r = xe / ye;
      OP_AND:  r = xe & ye;
      OP_OR:   r = xe | ye;
      OP_XOR:  r = xe ^ ye;
      OP_NAND: r = {4'b0000, ~(x & y)};
      OP_NOR:  r = {4'b0000, ~(x | y)};
      OP_NOT:  r = ~{y, x};
      OP_MOD:  r = xe % ye;
      OP_SHL:  r = xe << y;
      OP_SHR:  r = xe >> y;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Command/result bundle between requesters, the scheduler and the result consumer.
interface alu_rr_scheduler_if
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
);
  localparam int unsigned TAG_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [OPND_W*NUM_REQ-1:0] req_op;
  logic [OPND_W*NUM_REQ-1:0] req_x;
  logic [OPND_W*NUM_REQ-1:0] req_y;
  logic                      res_valid;
  logic                      res_ready;
  logic [RES_W-1:0]          res_data;
  logic [TAG_W-1:0]          res_tag;
  logic                      res_err;

  modport master (
    output req_valid, req_op, req_x, req_y, res_ready,
    input  req_ready, res_valid, res_data, res_tag, res_err
  );

  modport slave (
    input  req_valid, req_op, req_x, req_y, res_ready,
    output req_ready, res_valid, res_data, res_tag, res_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned idx;
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin shared 4-bit ALU with a registered tagged result port.
// Optional macro ALU_DIVZERO_TRAP_EN traps DIV/MOD by zero as 8'hFF with res_err set.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic             clk,
  input  logic             rst,
  alu_rr_scheduler_if.slave bus
);

  localparam int unsigned TAG_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic [TAG_W-1:0]   grant_idx;
  logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               res_valid_q;
  logic [RES_W-1:0]   res_data_q, res_data_d;
  logic [TAG_W-1:0]   res_tag_q;
  logic               res_err_q, res_err_d;
  logic               can_accept;
  logic               accept;
  alu_cmd_t           cmd;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign can_accept    = !res_valid_q || bus.res_ready;
  assign bus.req_ready = rst ? '0 : (grant & {NUM_REQ{can_accept}});
  assign accept        = |bus.req_ready;

  always_comb begin
    cmd = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        cmd.op = bus.req_op[i*OPND_W +: OPND_W];
        cmd.x  = bus.req_x [i*OPND_W +: OPND_W];
        cmd.y  = bus.req_y [i*OPND_W +: OPND_W];
      end
    end
  end

  always_comb begin
    res_data_d = alu_eval(cmd.op, cmd.x, cmd.y);
    res_err_d  = (cmd.op > OP_LAST);
`ifdef ALU_DIVZERO_TRAP_EN
    if ((cmd.op == OP_DIV || cmd.op == OP_MOD) && cmd.y == '0) begin
      res_data_d = 8'hFF;
      res_err_d  = 1'b1;
    end
`endif
    rr_ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
      rr_ptr_q    <= '0;
    end else if (accept) begin
      res_valid_q <= 1'b1;
      res_data_q  <= res_data_d;
      res_tag_q   <= grant_idx;
      res_err_q   <= res_err_d;
      rr_ptr_q    <= rr_ptr_d;
    end else if (bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_tag   = res_tag_q;
  assign bus.res_err   = res_err_q;

endmodule
